// File: rtl/arcanoid_ball_ctl.sv
// Per-frame ball, lives and game-state sequencer for the 800x600 Arkanoid pipeline.
// Latency: outputs update 1 pclk after the vblnk rising edge, flagged by frame_tick.
// Backpressure: none; the frame tick is free-running and every input is sampled as it comes.
module arcanoid_ball_ctl #(
    parameter int H_RES       = 800,
    parameter int V_RES       = 600,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_Y    = 560,
    parameter int PADDLE_W    = 96,
    parameter int SPEED       = 2,
    parameter int LIVES       = 3,
    parameter int LOST_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        vblnk,
    input  logic        btn_start,
    input  logic [10:0] paddle_x,
    input  logic        brick_hit,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_LOST = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int CW = $clog2(LOST_FRAMES + 1);

    localparam logic [11:0] H12   = 12'(H_RES);
    localparam logic [11:0] V12   = 12'(V_RES);
    localparam logic [11:0] BS12  = 12'(BALL_SIZE);
    localparam logic [11:0] PY12  = 12'(PADDLE_Y);
    localparam logic [11:0] PW12  = 12'(PADDLE_W);
    localparam logic [11:0] SPD12 = 12'(SPEED);

    localparam logic [10:0] SPD11    = 11'(SPEED);
    localparam logic [10:0] X_RIGHT  = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] Y_REST   = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] X_RESET  = 11'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [10:0] IDLE_OFF = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [1:0]  LIVES2   = 2'(LIVES);
    localparam logic [CW-1:0] LOST_LAST = CW'(LOST_FRAMES - 1);

    state_t        st;
    logic          vblnk_d;
    logic          dx_pos;
    logic          dy_pos;
    logic          brick_flag;
    logic [CW-1:0] lost_cnt;

    logic          tick;
    logic [11:0]   x12, y12, px12;
    logic          x_lo, x_hi, paddle_hit, loss, top_hit;
    logic [10:0]   x_step, y_up, y_dn;

    assign tick  = vblnk & ~vblnk_d;
    assign state = st;

    // Edge tests run on 12-bit copies so sums near the right/bottom edge cannot wrap.
    assign x12  = {1'b0, ball_x};
    assign y12  = {1'b0, ball_y};
    assign px12 = {1'b0, paddle_x};

    assign x_lo       = !dx_pos && (x12 <= SPD12);
    assign x_hi       = dx_pos && (x12 + BS12 + SPD12 >= H12);
    assign paddle_hit = dy_pos && (y12 + BS12 <= PY12) && (y12 + BS12 + SPD12 >= PY12)
                        && (x12 + BS12 > px12) && (x12 < px12 + PW12);
    assign loss       = dy_pos && (y12 + BS12 + SPD12 >= V12) && !paddle_hit;
    assign top_hit    = !dy_pos && (y12 <= SPD12);

    assign x_step = dx_pos ? ball_x + SPD11 : ball_x - SPD11;
    assign y_up   = ball_y - SPD11;
    assign y_dn   = ball_y + SPD11;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            vblnk_d    <= 1'b0;
            frame_tick <= 1'b0;
            ball_x     <= X_RESET;
            ball_y     <= Y_REST;
            dx_pos     <= 1'b1;
            dy_pos     <= 1'b0;
            lives      <= LIVES2;
            brick_flag <= 1'b0;
            lost_cnt   <= '0;
        end else begin
            vblnk_d    <= vblnk;
            frame_tick <= tick;

            // A hit landing on the tick cycle itself is dropped by design.
            if (tick)
                brick_flag <= 1'b0;
            else if (brick_hit)
                brick_flag <= 1'b1;

            if (tick) begin
                case (st)
                    ST_IDLE: begin
                        ball_x <= paddle_x + IDLE_OFF;
                        ball_y <= Y_REST;
                        if (btn_start) begin
                            st     <= ST_PLAY;
                            dx_pos <= 1'b1;
                            dy_pos <= 1'b0;
                        end
                    end
                    ST_PLAY: begin
                        if (loss) begin
                            lives <= lives - 2'd1;
                            st    <= ST_LOST;
                        end else begin
                            if (x_lo) begin
                                ball_x <= '0;
                                dx_pos <= 1'b1;
                            end else if (x_hi) begin
                                ball_x <= X_RIGHT;
                                dx_pos <= 1'b0;
                            end else begin
                                ball_x <= x_step;
                            end

                            if (paddle_hit) begin
                                ball_y <= Y_REST;
                                dy_pos <= 1'b0;
                            end else if (top_hit) begin
                                ball_y <= '0;
                                dy_pos <= 1'b1;
                            end else if (brick_flag) begin
                                ball_y <= dy_pos ? y_up : y_dn;
                                dy_pos <= !dy_pos;
                            end else begin
                                ball_y <= dy_pos ? y_dn : y_up;
                            end
                        end
                    end
                    ST_LOST: begin
                        if (lost_cnt == LOST_LAST) begin
                            lost_cnt <= '0;
                            st       <= (lives != 2'd0) ? ST_IDLE : ST_OVER;
                        end else begin
                            lost_cnt <= lost_cnt + 1'b1;
                        end
                    end
                    ST_OVER: begin
                        if (btn_start) begin
                            lives <= LIVES2;
                            st    <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arcanoid_ball_ctl.sv
// Directed bench for arcanoid_ball_ctl: one ball trajectory walked through every wall,
// paddle, brick, loss and game-over case, with positions worked out by hand.
module tb_arcanoid_ball_ctl;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        vblnk = 1'b0;
    logic        btn_start = 1'b0;
    logic [10:0] paddle_x = 11'd100;
    logic        brick_hit = 1'b0;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [1:0]  state;
    logic [1:0]  lives;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    arcanoid_ball_ctl dut (
        .pclk       (pclk),
        .reset      (reset),
        .vblnk      (vblnk),
        .btn_start  (btn_start),
        .paddle_x   (paddle_x),
        .brick_hit  (brick_hit),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .state      (state),
        .lives      (lives),
        .frame_tick (frame_tick)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk) vblnk = 1'b1;
            @(negedge pclk) vblnk = 1'b0;
            @(negedge pclk);
        end
    endtask

    task automatic tick_with_hit();
        @(negedge pclk) begin vblnk = 1'b1; brick_hit = 1'b1; end
        @(negedge pclk) begin vblnk = 1'b0; brick_hit = 1'b0; end
        @(negedge pclk);
    endtask

    task automatic pulse_brick();
        @(negedge pclk) brick_hit = 1'b1;
        @(negedge pclk) brick_hit = 1'b0;
    endtask

    task automatic wait_loss(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            run_ticks(1);
            if (state == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({ball_x, ball_y} !== {11'd396, 11'd552}) begin
            bad++; $display("FAIL reset_ball: got (%0d,%0d) want (396,552)", ball_x, ball_y);
        end
        total++;
        if ({state, lives, frame_tick} !== {2'd0, 2'd3, 1'b0}) begin
            bad++; $display("FAIL reset_ctl: got st=%0d lives=%0d ft=%0b want st=0 lives=3 ft=0", state, lives, frame_tick);
        end
        @(negedge pclk) reset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_idle();
        paddle_x = 11'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk) vblnk = 1'b1;
            total++;
            if (frame_tick !== 1'b0) begin
                bad++; $display("FAIL idle_ft_early: got %0b want 0", frame_tick);
            end
            @(posedge pclk); #1;
            total++;
            if (frame_tick !== 1'b1) begin
                bad++; $display("FAIL idle_ft_pulse: got %0b want 1", frame_tick);
            end
            total++;
            if ({state, ball_x, ball_y, lives} !== {2'd0, 11'd144, 11'd552, 2'd3}) begin
                bad++; $display("FAIL idle_track: got st=%0d (%0d,%0d) lives=%0d want st=0 (144,552) lives=3", state, ball_x, ball_y, lives);
            end
            @(negedge pclk) vblnk = 1'b0;
            @(posedge pclk); #1;
            total++;
            if (frame_tick !== 1'b0) begin
                bad++; $display("FAIL idle_ft_width: got %0b want 0", frame_tick);
            end
        end
        paddle_x = 11'd101;
        run_ticks(1);
        total++;
        if ({state, ball_x} !== {2'd0, 11'd145}) begin
            bad++; $display("FAIL idle_follow: got st=%0d x=%0d want st=0 x=145", state, ball_x);
        end
    endtask

    task automatic test_serve();
        btn_start = 1'b1;
        run_ticks(1);
        btn_start = 1'b0;
        total++;
        if ({state, ball_x, ball_y} !== {2'd1, 11'd145, 11'd552}) begin
            bad++; $display("FAIL serve: got st=%0d (%0d,%0d) want st=1 (145,552)", state, ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd147, 11'd550}) begin
            bad++; $display("FAIL serve_move: got (%0d,%0d) want (147,550)", ball_x, ball_y);
        end
    endtask

    task automatic test_walls();
        run_ticks(274);
        total++;
        if ({ball_x, ball_y} !== {11'd695, 11'd2}) begin
            bad++; $display("FAIL top_approach: got (%0d,%0d) want (695,2)", ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd697, 11'd0}) begin
            bad++; $display("FAIL top_clamp: got (%0d,%0d) want (697,0)", ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd699, 11'd2}) begin
            bad++; $display("FAIL top_rebound: got (%0d,%0d) want (699,2)", ball_x, ball_y);
        end
        run_ticks(46);
        total++;
        if ({ball_x, ball_y} !== {11'd791, 11'd94}) begin
            bad++; $display("FAIL right_approach: got (%0d,%0d) want (791,94)", ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd792, 11'd96}) begin
            bad++; $display("FAIL right_clamp: got (%0d,%0d) want (792,96)", ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd790, 11'd98}) begin
            bad++; $display("FAIL right_rebound: got (%0d,%0d) want (790,98)", ball_x, ball_y);
        end
    endtask

    task automatic test_paddle_bounce();
        paddle_x = 11'd300;
        run_ticks(226);
        total++;
        if ({state, ball_x, ball_y} !== {2'd1, 11'd338, 11'd550}) begin
            bad++; $display("FAIL paddle_approach: got st=%0d (%0d,%0d) want st=1 (338,550)", state, ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({state, ball_x, ball_y} !== {2'd1, 11'd336, 11'd552}) begin
            bad++; $display("FAIL paddle_hit: got st=%0d (%0d,%0d) want st=1 (336,552)", state, ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd334, 11'd550}) begin
            bad++; $display("FAIL paddle_rebound: got (%0d,%0d) want (334,550)", ball_x, ball_y);
        end
    endtask

    task automatic test_brick();
        run_ticks(124);
        total++;
        if ({ball_x, ball_y} !== {11'd86, 11'd302}) begin
            bad++; $display("FAIL brick_approach: got (%0d,%0d) want (86,302)", ball_x, ball_y);
        end
        tick_with_hit();
        total++;
        if ({ball_x, ball_y} !== {11'd84, 11'd300}) begin
            bad++; $display("FAIL brick_on_tick_lost: got (%0d,%0d) want (84,300)", ball_x, ball_y);
        end
        pulse_brick();
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd82, 11'd302}) begin
            bad++; $display("FAIL brick_bounce: got (%0d,%0d) want (82,302)", ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd80, 11'd304}) begin
            bad++; $display("FAIL brick_consumed: got (%0d,%0d) want (80,304)", ball_x, ball_y);
        end
    endtask

    task automatic test_left_wall();
        run_ticks(39);
        total++;
        if ({ball_x, ball_y} !== {11'd2, 11'd382}) begin
            bad++; $display("FAIL left_approach: got (%0d,%0d) want (2,382)", ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd0, 11'd384}) begin
            bad++; $display("FAIL left_clamp: got (%0d,%0d) want (0,384)", ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({ball_x, ball_y} !== {11'd2, 11'd386}) begin
            bad++; $display("FAIL left_rebound: got (%0d,%0d) want (2,386)", ball_x, ball_y);
        end
    endtask

    task automatic test_loss();
        paddle_x = 11'd600;
        run_ticks(82);
        run_ticks(1);
        total++;
        if ({state, ball_x, ball_y} !== {2'd1, 11'd168, 11'd552}) begin
            bad++; $display("FAIL paddle_miss: got st=%0d (%0d,%0d) want st=1 (168,552)", state, ball_x, ball_y);
        end
        run_ticks(19);
        total++;
        if ({state, lives, ball_x, ball_y} !== {2'd1, 2'd3, 11'd206, 11'd590}) begin
            bad++; $display("FAIL loss_approach: got st=%0d lives=%0d (%0d,%0d) want st=1 lives=3 (206,590)", state, lives, ball_x, ball_y);
        end
        run_ticks(1);
        total++;
        if ({state, lives, ball_x, ball_y} !== {2'd2, 2'd2, 11'd206, 11'd590}) begin
            bad++; $display("FAIL loss: got st=%0d lives=%0d (%0d,%0d) want st=2 lives=2 (206,590)", state, lives, ball_x, ball_y);
        end
    endtask

    task automatic test_lost_hold_btn();
        bit ok;
        run_ticks(59);
        total++;
        if ({state, ball_x, ball_y} !== {2'd2, 11'd206, 11'd590}) begin
            bad++; $display("FAIL lost_hold: got st=%0d (%0d,%0d) want st=2 (206,590)", state, ball_x, ball_y);
        end
        btn_start = 1'b1;
        run_ticks(1);
        total++;
        if ({state, lives} !== {2'd0, 2'd2}) begin
            bad++; $display("FAIL lost_exit: got st=%0d lives=%0d want st=0 lives=2", state, lives);
        end
        run_ticks(1);
        btn_start = 1'b0;
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL held_btn_serve: got st=%0d want 1", state);
        end
        wait_loss(2000, ok);
        total++;
        if (!ok || lives !== 2'd1) begin
            bad++; $display("FAIL second_loss: got reached=%0b lives=%0d want reached=1 lives=1", ok, lives);
        end
        run_ticks(60);
        total++;
        if (state !== 2'd0) begin
            bad++; $display("FAIL second_lost_exit: got st=%0d want 0", state);
        end
    endtask

    task automatic test_last_life();
        bit ok;
        btn_start = 1'b1;
        run_ticks(1);
        btn_start = 1'b0;
        wait_loss(2000, ok);
        total++;
        if (!ok || lives !== 2'd0) begin
            bad++; $display("FAIL last_loss: got reached=%0b lives=%0d want reached=1 lives=0", ok, lives);
        end
        run_ticks(59);
        total++;
        if (state !== 2'd2) begin
            bad++; $display("FAIL last_lost_hold: got st=%0d want 2", state);
        end
        run_ticks(1);
        total++;
        if ({state, lives} !== {2'd3, 2'd0}) begin
            bad++; $display("FAIL game_over: got st=%0d lives=%0d want st=3 lives=0", state, lives);
        end
    endtask

    task automatic test_over();
        run_ticks(1);
        total++;
        if ({state, lives} !== {2'd3, 2'd0}) begin
            bad++; $display("FAIL over_stay: got st=%0d lives=%0d want st=3 lives=0", state, lives);
        end
        btn_start = 1'b1;
        run_ticks(1);
        btn_start = 1'b0;
        total++;
        if ({state, lives} !== {2'd0, 2'd3}) begin
            bad++; $display("FAIL restart: got st=%0d lives=%0d want st=0 lives=3", state, lives);
        end
    endtask

    task automatic test_reset_in_lost();
        bit ok;
        btn_start = 1'b1;
        run_ticks(1);
        btn_start = 1'b0;
        wait_loss(2000, ok);
        total++;
        if (!ok || lives !== 2'd2) begin
            bad++; $display("FAIL pre_reset_loss: got reached=%0b lives=%0d want reached=1 lives=2", ok, lives);
        end
        run_ticks(10);
        @(negedge pclk) vblnk = 1'b1;
        @(posedge pclk); #1;
        total++;
        if ({state, frame_tick} !== {2'd2, 1'b1}) begin
            bad++; $display("FAIL pre_reset_tick: got st=%0d ft=%0b want st=2 ft=1", state, frame_tick);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({state, lives, frame_tick, ball_x, ball_y} !== {2'd0, 2'd3, 1'b0, 11'd396, 11'd552}) begin
            bad++; $display("FAIL async_reset: got st=%0d lives=%0d ft=%0b (%0d,%0d) want st=0 lives=3 ft=0 (396,552)", state, lives, frame_tick, ball_x, ball_y);
        end
        @(negedge pclk) vblnk = 1'b0;
        @(negedge pclk) begin reset = 1'b0; paddle_x = 11'd200; end
        run_ticks(1);
        total++;
        if ({state, lives, ball_x, ball_y} !== {2'd0, 2'd3, 11'd244, 11'd552}) begin
            bad++; $display("FAIL post_reset_idle: got st=%0d lives=%0d (%0d,%0d) want st=0 lives=3 (244,552)", state, lives, ball_x, ball_y);
        end
        btn_start = 1'b1;
        run_ticks(1);
        btn_start = 1'b0;
        run_ticks(1);
        total++;
        if ({state, ball_x, ball_y} !== {2'd1, 11'd246, 11'd550}) begin
            bad++; $display("FAIL post_reset_play: got st=%0d (%0d,%0d) want st=1 (246,550)", state, ball_x, ball_y);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_serve();
        test_walls();
        test_paddle_bounce();
        test_brick();
        test_left_wall();
        test_loss();
        test_lost_hold_btn();
        test_last_life();
        test_over();
        test_reset_in_lost();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
